// File: rtl/mem_modport.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_modport
// Description : Single-port synchronous 64x16 memory behind a valid/ready bus;
//               registered read data, ready asserted one edge after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_modport #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_ready;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_xfer;

    // A request is only taken once ready is up; earlier requests are dropped.
    assign w_xfer = valid_i & r_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else if (w_xfer) begin
            if (wr_rd_i) begin
                r_mem[addr_i] <= wr_data_i;
            end else begin
                r_rd_data <= r_mem[addr_i];
            end
        end
    end

    assign ready_o   = r_ready;
    assign rd_data_o = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_modport.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_modport
// Description : Scoreboard bench for mem_modport: reset, sweep, hold, RAW,
//               asynchronous mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_modport;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        wr_rd_i;
    logic [5:0]  addr_i;
    logic [15:0] wr_data_i;
    logic        ready_o;
    logic [15:0] rd_data_o;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model [64];
    logic [15:0] exp_q [$];
    logic [15:0] last_rd;

    mem_modport dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .wr_rd_i   (wr_rd_i),
        .addr_i    (addr_i),
        .wr_data_i (wr_data_i),
        .ready_o   (ready_o),
        .rd_data_o (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic issue(input logic wr, input logic [5:0] a, input logic [15:0] d);
        logic [15:0] exp;
        valid_i   = 1'b1;
        wr_rd_i   = wr;
        addr_i    = a;
        wr_data_i = d;
        if (wr) model[a] = d;
        else    exp_q.push_back(model[a]);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        checks++;
        if (wr) begin
            if (rd_data_o !== last_rd) begin
                errors++;
                $display("FAIL write_keeps_rd addr=%0d actual=%h expected=%h", a, rd_data_o, last_rd);
            end
        end else begin
            exp = exp_q.pop_front();
            if (rd_data_o !== exp) begin
                errors++;
                $display("FAIL read addr=%0d actual=%h expected=%h", a, rd_data_o, exp);
            end
            last_rd = exp;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 16'h0000;
        last_rd = 16'h0000;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; wr_rd_i = 1'b0; addr_i = '0; wr_data_i = '0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b expected=0", ready_o); end
        checks++;
        if (rd_data_o !== 16'h0000) begin errors++; $display("FAIL reset_rd actual=%h expected=0000", rd_data_o); end
        rst_i = 1'b0;
        // This request meets ready=0 at the next edge and must be dropped.
        valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 6'd7; wr_data_i = 16'hBEEF;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_before_edge actual=%b expected=0", ready_o); end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_edge actual=%b expected=1", ready_o); end
        issue(1'b0, 6'd7, 16'h0000);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 64; i++) issue(1'b1, 6'(i), 16'(i * 257));
        for (int i = 0; i < 64; i++) issue(1'b0, 6'(i), 16'h0000);
        checks++;
        if (rd_data_o !== 16'h3F3F) begin errors++; $display("FAIL sweep_last actual=%h expected=3f3f", rd_data_o); end
    endtask

    task automatic test_single();
        issue(1'b1, 6'd5, 16'hA5A5);
        issue(1'b0, 6'd5, 16'h0000);
        checks++;
        if (rd_data_o !== 16'hA5A5) begin errors++; $display("FAIL single actual=%h expected=a5a5", rd_data_o); end
    endtask

    task automatic test_hold_idle();
        issue(1'b0, 6'd5, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            valid_i   = 1'b0;
            wr_rd_i   = 1'($urandom);
            addr_i    = 6'($urandom);
            wr_data_i = 16'($urandom);
            @(posedge clk_i);
            #1;
            checks++;
            if (rd_data_o !== 16'hA5A5) begin
                errors++;
                $display("FAIL hold cycle=%0d actual=%h expected=a5a5", c, rd_data_o);
            end
        end
        for (int i = 0; i < 8; i++) issue(1'b0, 6'($urandom_range(0, 63)), 16'h0000);
        issue(1'b0, 6'd5, 16'h0000);
    endtask

    task automatic test_write_then_read();
        issue(1'b1, 6'd10, 16'h1234);
        issue(1'b0, 6'd10, 16'h0000);
        checks++;
        if (rd_data_o !== 16'h1234) begin errors++; $display("FAIL raw actual=%h expected=1234", rd_data_o); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 6'd40, 16'hC0DE);
        issue(1'b0, 6'd40, 16'h0000);
        issue(1'b1, 6'd41, 16'h5A5A);
        issue(1'b0, 6'd63, 16'h0000);
        issue(1'b0, 6'd41, 16'h0000);
        issue(1'b0, 6'd0,  16'h0000);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 6'd3,  16'h1111);
        issue(1'b1, 6'd20, 16'h2222);
        issue(1'b0, 6'd20, 16'h0000);
        valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 6'd3; wr_data_i = 16'hFFFF;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ready actual=%b expected=0", ready_o); end
        checks++;
        if (rd_data_o !== 16'h0000) begin errors++; $display("FAIL mid_reset_rd actual=%h expected=0000", rd_data_o); end
        valid_i = 1'b0;
        clear_model();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_recover actual=%b expected=1", ready_o); end
        issue(1'b0, 6'd3,  16'h0000);
        issue(1'b0, 6'd20, 16'h0000);
        issue(1'b0, 6'd10, 16'h0000);
        issue(1'b0, 6'd63, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single();
        test_hold_idle();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
